// File: rtl/draw_hand.sv
`default_nettype none
// ============================================================================
// Module   : draw_hand
// Brief    : Holds up to MAX_CARDS dealt cards and overlays them on a VGA
//            stream through an external card ROM.
// Revision : 1.0 - initial release
// ============================================================================
module draw_hand #(
  parameter int          MAX_CARDS = 6,
  parameter int          X_START   = 100,
  parameter int          Y_START   = 400,
  parameter int          CARD_W    = 64,
  parameter int          CARD_H    = 96,
  parameter int          X_STEP    = 24,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] TRANSP    = 12'h0F0,
  parameter int          ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       vga_in_vcount,
  input  logic              vga_in_vsync,
  input  logic              vga_in_vblnk,
  input  logic [10:0]       vga_in_hcount,
  input  logic              vga_in_hsync,
  input  logic              vga_in_hblnk,
  input  logic [11:0]       vga_in_rgb,
  output logic [10:0]       vga_out_vcount,
  output logic              vga_out_vsync,
  output logic              vga_out_vblnk,
  output logic [10:0]       vga_out_hcount,
  output logic              vga_out_hsync,
  output logic              vga_out_hblnk,
  output logic [11:0]       vga_out_rgb,
  input  logic              card_valid,
  output logic              card_ready,
  input  logic [6:0]        card_number_in,
  input  logic [3:0]        card_symbol_in,
  input  logic              hand_clr,
  output logic [3:0]        hand_count,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [6:0]        card_number,
  output logic [3:0]        card_symbol,
  input  logic [11:0]       rgb_pixel
);

  localparam int          c_vga_w     = 38;
  localparam logic [10:0] c_y_start   = 11'(Y_START);
  localparam logic [10:0] c_card_w    = 11'(CARD_W);
  localparam logic [10:0] c_card_h    = 11'(CARD_H);
  localparam logic [3:0]  c_max_cards = 4'(MAX_CARDS);

  function automatic logic [10:0] slot_x(input int i);
    return 11'(X_START + i * X_STEP);
  endfunction

  logic [3:0]  r_hand_count;
  logic [6:0]  r_num  [MAX_CARDS];
  logic [3:0]  r_sym  [MAX_CARDS];
  logic [3:0]  r_disp_count;
  logic [6:0]  r_dnum [MAX_CARDS];
  logic [3:0]  r_dsym [MAX_CARDS];
  logic        r_vblnk_d;
  logic        w_ready;
  logic        w_push;
  logic        w_vblnk_rise;

  assign w_ready      = !rst && (r_hand_count < c_max_cards) && !hand_clr;
  assign w_push       = card_valid && w_ready;
  assign w_vblnk_rise = vga_in_vblnk && !r_vblnk_d;
  assign card_ready   = w_ready;
  assign hand_count   = r_hand_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hand_count <= '0;
      for (int i = 0; i < MAX_CARDS; i++) begin
        r_num[i] <= '0;
        r_sym[i] <= '0;
      end
    end else if (hand_clr) begin
      r_hand_count <= '0;
    end else if (w_push) begin
      r_hand_count <= r_hand_count + 4'd1;
      for (int i = 0; i < MAX_CARDS; i++) begin
        if (r_hand_count == 4'(i)) begin
          r_num[i] <= card_number_in;
          r_sym[i] <= card_symbol_in;
        end
      end
    end
  end

  // The drawn hand only changes at the start of vertical blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d    <= 1'b0;
      r_disp_count <= '0;
      for (int i = 0; i < MAX_CARDS; i++) begin
        r_dnum[i] <= '0;
        r_dsym[i] <= '0;
      end
    end else begin
      r_vblnk_d <= vga_in_vblnk;
      if (w_vblnk_rise) begin
        r_disp_count <= r_hand_count;
        for (int i = 0; i < MAX_CARDS; i++) begin
          r_dnum[i] <= r_num[i];
          r_dsym[i] <= r_sym[i];
        end
      end
    end
  end

  logic              w_in_y;
  logic              w_hit;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic [6:0]        w_num;
  logic [3:0]        w_sym;
  logic [ADDR_W-1:0] w_addr;

  // Later slots overwrite earlier ones, so the most recently dealt card wins.
  always_comb begin
    w_in_y = (vga_in_vcount >= c_y_start) && ((vga_in_vcount - c_y_start) < c_card_h);
    w_dy   = vga_in_vcount - c_y_start;
    w_hit  = 1'b0;
    w_dx   = '0;
    w_num  = '0;
    w_sym  = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (w_in_y && (4'(i) < r_disp_count) && (vga_in_hcount >= slot_x(i)) &&
          ((vga_in_hcount - slot_x(i)) < c_card_w)) begin
        w_hit = 1'b1;
        w_dx  = vga_in_hcount - slot_x(i);
        w_num = r_dnum[i];
        w_sym = r_dsym[i];
      end
    end
    w_addr = ADDR_W'(w_dy) * ADDR_W'(CARD_W) + ADDR_W'(w_dx);
  end

  logic [c_vga_w-1:0] w_vga_in;
  logic [c_vga_w-1:0] r_vpipe [ROM_LAT+1];
  logic [ROM_LAT:0]   r_hit;
  logic [c_vga_w-1:0] r_vout;
  logic [11:0]        w_rgb_out;
  logic [ADDR_W-1:0]  r_pixel_addr;
  logic [6:0]         r_card_number;
  logic [3:0]         r_card_symbol;

  assign w_vga_in  = {vga_in_vcount, vga_in_vsync, vga_in_vblnk,
                      vga_in_hcount, vga_in_hsync, vga_in_hblnk, vga_in_rgb};
  assign w_rgb_out = (r_hit[ROM_LAT] && (rgb_pixel != TRANSP)) ? rgb_pixel
                                                               : r_vpipe[ROM_LAT][11:0];

  // Index ROM_LAT of the pipeline lines up with the ROM data for its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel_addr  <= '0;
      r_card_number <= '0;
      r_card_symbol <= '0;
      r_hit         <= '0;
      r_vout        <= '0;
      for (int j = 0; j <= ROM_LAT; j++) r_vpipe[j] <= '0;
    end else begin
      r_pixel_addr  <= w_hit ? w_addr : '0;
      r_card_number <= w_num;
      r_card_symbol <= w_sym;
      r_vpipe[0]    <= w_vga_in;
      r_hit[0]      <= w_hit;
      for (int j = 1; j <= ROM_LAT; j++) begin
        r_vpipe[j] <= r_vpipe[j-1];
        r_hit[j]   <= r_hit[j-1];
      end
      r_vout <= {r_vpipe[ROM_LAT][c_vga_w-1:12], w_rgb_out};
    end
  end

  assign pixel_addr  = r_pixel_addr;
  assign card_number = r_card_number;
  assign card_symbol = r_card_symbol;
  assign {vga_out_vcount, vga_out_vsync, vga_out_vblnk,
          vga_out_hcount, vga_out_hsync, vga_out_hblnk, vga_out_rgb} = r_vout;

endmodule
`default_nettype wire
